// File: rtl/alu_mext_seq_if.sv
// Operation request / result bus between operand fetch, the ALU and writeback.
interface alu_mext_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3_;
    logic [6:0]      funct7_;
    logic [3:0]      instr_type;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] c;
    logic            busy;

    modport master (
        output in_valid, a, b, funct3_, funct7_, instr_type, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, funct3_, funct7_, instr_type, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/alu_mext_seq.sv
// Handshaked RV base + M-extension ALU. Base ops and trivial divides finish in one
// cycle; MUL* wait MUL_LAT cycles; DIV/REM run a radix-2 restoring divider.
//
// state  | meaning
// S_IDLE | ready for a new op (if the result register is free)
// S_MUL  | multiply in flight, down-counting the remaining latency
// S_DIV  | divide in flight, one quotient bit per cycle
// S_DONE | multi-cycle result just presented; return to IDLE
module alu_mext_seq #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_mext_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] TYPE_R = 4'd0;
    localparam logic [3:0] TYPE_I = 4'd1;
    localparam logic [3:0] TYPE_S = 4'd2;
    localparam logic [3:0] TYPE_B = 4'd3;
    localparam logic [3:0] TYPE_U = 4'd4;
    localparam logic [3:0] TYPE_J = 4'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_next;

    logic [XLEN-1:0]  c_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  op_a, op_b;
    logic [2:0]       op_f3;
    logic             neg_q, neg_r;
    logic [XLEN-1:0]  quot_r, rem_r;
    logic [CNT_W-1:0] cnt;

    logic accept, start_mul, start_div, load_now, finish;

    assign bus.in_ready  = (state == S_IDLE) && (!out_valid_r || bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.c         = c_r;
    assign bus.busy      = (state == S_MUL) || (state == S_DIV);
    assign accept        = bus.in_valid && bus.in_ready;

    // ---------------- single-cycle base datapath ----------------
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    base_res;
    logic               lt_s, lt_u, f7_is_alt;

    assign shamt     = bus.b[SHAMT_W-1:0];
    assign lt_s      = $signed(bus.a) < $signed(bus.b);
    assign lt_u      = bus.a < bus.b;
    assign f7_is_alt = (bus.funct7_ == F7_ALT);

    // Base op result; R-type with an unrecognised funct7 yields zero.
    always_comb begin
        base_res = '0;
        case (bus.instr_type)
            TYPE_R: begin
                if (bus.funct7_ == F7_BASE) begin
                    case (bus.funct3_)
                        3'd0: base_res = bus.a + bus.b;
                        3'd1: base_res = bus.a << shamt;
                        3'd2: base_res = {{(XLEN-1){1'b0}}, lt_s};
                        3'd3: base_res = {{(XLEN-1){1'b0}}, lt_u};
                        3'd4: base_res = bus.a ^ bus.b;
                        3'd5: base_res = bus.a >> shamt;
                        3'd6: base_res = bus.a | bus.b;
                        default: base_res = bus.a & bus.b;
                    endcase
                end else if (f7_is_alt) begin
                    if (bus.funct3_ == 3'd0)
                        base_res = bus.a - bus.b;
                    else if (bus.funct3_ == 3'd5)
                        base_res = XLEN'($signed(bus.a) >>> shamt);
                end
            end
            TYPE_I: begin
                case (bus.funct3_)
                    3'd0: base_res = bus.a + bus.b;
                    3'd1: base_res = bus.a << shamt;
                    3'd2: base_res = {{(XLEN-1){1'b0}}, lt_s};
                    3'd3: base_res = {{(XLEN-1){1'b0}}, lt_u};
                    3'd4: base_res = bus.a ^ bus.b;
                    3'd5: base_res = f7_is_alt ? XLEN'($signed(bus.a) >>> shamt)
                                               : bus.a >> shamt;
                    3'd6: base_res = bus.a | bus.b;
                    default: base_res = bus.a & bus.b;
                endcase
            end
            TYPE_S, TYPE_J: base_res = bus.a + bus.b;
            TYPE_U:         base_res = bus.b;
            TYPE_B: begin
                case (bus.funct3_)
                    3'd0: base_res = {{(XLEN-1){1'b0}}, bus.a == bus.b};
                    3'd1: base_res = {{(XLEN-1){1'b0}}, bus.a != bus.b};
                    3'd4: base_res = {{(XLEN-1){1'b0}}, lt_s};
                    3'd5: base_res = {{(XLEN-1){1'b0}}, !lt_s};
                    3'd6: base_res = {{(XLEN-1){1'b0}}, lt_u};
                    3'd7: base_res = {{(XLEN-1){1'b0}}, !lt_u};
                    default: base_res = '0;
                endcase
            end
            default: base_res = '0;
        endcase
    end

    // ---------------- M-extension decode ----------------
    logic            is_mext, is_mul, is_div, div_signed, div_rem;
    logic            b_zero, div_ovf, fast_div, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    assign is_mext    = (bus.instr_type == TYPE_R) && (bus.funct7_ == F7_MEXT);
    assign is_mul     = is_mext && !bus.funct3_[2];
    assign is_div     = is_mext && bus.funct3_[2];
    assign div_signed = !bus.funct3_[0];
    assign div_rem    = bus.funct3_[1];
    assign b_zero     = (bus.b == '0);
    assign div_ovf    = div_signed && (bus.a == MIN_NEG) && (bus.b == ALL_ONE);
    assign fast_div   = b_zero || div_ovf;
    assign a_neg      = div_signed && bus.a[XLEN-1];
    assign b_neg      = div_signed && bus.b[XLEN-1];
    assign a_mag      = a_neg ? -bus.a : bus.a;
    assign b_mag      = b_neg ? -bus.b : bus.b;

    // One-cycle result: base op, or a divide whose answer is fixed by b==0 / overflow.
    always_comb begin
        fast_res = base_res;
        if (is_div) begin
            if (b_zero)
                fast_res = div_rem ? bus.a : ALL_ONE;
            else
                fast_res = div_rem ? '0 : bus.a;
        end
    end

    // ---------------- multiplier ----------------
    // In IDLE the live operands feed the multiplier so MUL_LAT==1 can finish on accept.
    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic [2:0]        mul_f3;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;

    assign mul_a  = (state == S_IDLE) ? bus.a : op_a;
    assign mul_b  = (state == S_IDLE) ? bus.b : op_b;
    assign mul_f3 = (state == S_IDLE) ? bus.funct3_ : op_f3;

    // Operand extension chosen by signedness: MULH s*s, MULHSU s*u, MULHU u*u.
    always_comb begin
        ext_a = {{XLEN{1'b0}}, mul_a};
        ext_b = {{XLEN{1'b0}}, mul_b};
        if (mul_f3[1:0] == 2'b01 || mul_f3[1:0] == 2'b10)
            ext_a = {{XLEN{mul_a[XLEN-1]}}, mul_a};
        if (mul_f3[1:0] == 2'b01)
            ext_b = {{XLEN{mul_b[XLEN-1]}}, mul_b};
        prod    = ext_a * ext_b;
        mul_res = (mul_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // ---------------- restoring divider step ----------------
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] quot_step, rem_step, div_res, done_res;

    // One restoring iteration on magnitudes; signs are applied to the stepped values.
    always_comb begin
        shifted = {rem_r, quot_r[XLEN-1]};
        diff    = shifted - {1'b0, op_b};
        if (diff[XLEN]) begin
            rem_step  = shifted[XLEN-1:0];
            quot_step = {quot_r[XLEN-2:0], 1'b0};
        end else begin
            rem_step  = diff[XLEN-1:0];
            quot_step = {quot_r[XLEN-2:0], 1'b1};
        end
        if (op_f3[1])
            div_res = neg_r ? -rem_step : rem_step;
        else
            div_res = neg_q ? -quot_step : quot_step;
        done_res = (state == S_DIV) ? div_res : mul_res;
    end

    // ---------------- control FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_next = state;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        load_now   = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        start_mul = 1'b1;
                        if (MUL_LAT <= 1) begin
                            finish     = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            state_next = S_MUL;
                        end
                    end else if (is_div && !fast_div) begin
                        start_div  = 1'b1;
                        state_next = S_DIV;
                    end else begin
                        load_now = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Result register, operand capture, latency counter and divider registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r         <= '0;
            out_valid_r <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_f3       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            cnt         <= '0;
        end else begin
            if (out_valid_r && bus.out_ready)
                out_valid_r <= 1'b0;
            if (load_now) begin
                c_r         <= fast_res;
                out_valid_r <= 1'b1;
            end
            if (finish) begin
                c_r         <= done_res;
                out_valid_r <= 1'b1;
            end
            if (start_mul) begin
                op_a  <= bus.a;
                op_b  <= bus.b;
                op_f3 <= bus.funct3_;
                cnt   <= CNT_W'(MUL_LAT - 1);
            end else if (start_div) begin
                op_b   <= b_mag;
                op_f3  <= bus.funct3_;
                quot_r <= a_mag;
                rem_r  <= '0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                cnt    <= CNT_W'(XLEN);
            end else if (state == S_MUL) begin
                cnt <= cnt - 1'b1;
            end else if (state == S_DIV) begin
                quot_r <= quot_step;
                rem_r  <= rem_step;
                cnt    <= cnt - 1'b1;
            end
        end
    end
endmodule
